sobel_edge_stream: RTL and testbench
====================================

Name: sobel_edge_stream

Overview:
- Streaming 3x3 Sobel edge-magnitude stage between the camera grayscale path and the zebra-crossing detector.
- Takes one grayscale pixel per valid strobe in raster order and emits exactly one edge-magnitude pixel per input pixel, so the downstream per-frame pixel count of IMG_WIDTH*IMG_HEIGHT is preserved.
- Uses two line buffers and a 3x3 window register, with a fixed 2-cycle valid-to-valid pipeline.

Parameters:
- IMG_WIDTH, 320, pixels per row
- IMG_HEIGHT, 240, rows per frame
- W, 8, pixel width for input and output
- MAG_SHIFT, 0, right shift applied to the raw magnitude before saturation

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- pix_valid  input  1  input pixel strobe; may have arbitrary gaps
- pix_sof  input  1  start of frame; qualified by pix_valid; marks the pixel at (0,0)
- pix_in  input  W  unsigned grayscale pixel
- edge_valid  output  1  output strobe; exactly pix_valid delayed 2 cycles
- edge_pixel  output  W  saturated edge magnitude
- edge_x  output  $clog2(IMG_WIDTH)  input column x that produced this output (debug/alignment)

Behaviour:
- Reset:
  - edge_valid=0, edge_pixel=0, edge_x=0.
  - x/y counters=0; window registers=0; pipeline valids=0.
  - Line buffer contents are not cleared; border masking makes them don't-care.
- Position tracking, advanced only on pix_valid:
  - x increments; at x==IMG_WIDTH-1, x wraps to 0 and y increments.
  - At y==IMG_HEIGHT-1 with x==IMG_WIDTH-1, both wrap to 0.
- pix_sof:
  - pix_sof && pix_valid: the current pixel is processed as (0,0) regardless of counter state; counters continue from (1,0).
  - pix_sof without pix_valid is ignored.
- Line buffers (two, IMG_WIDTH x W):
  - On each valid pixel at column x: read lb0[x] (row y-1) and lb1[x] (row y-2).
  - Then write lb1[x]<=old lb0[x] and lb0[x]<=pix_in. Read-before-write in the same cycle.
- Window:
  - On valid, shift the 3x3 window left by one column.
  - New right column = {lb1[x], lb0[x], pix_in} (top to bottom).
  - Window centre corresponds to (x-1, y-1).
- Stage 1 (cycle after valid): window registered; v1=1; border flag registered.
  - Border flag = (x<2) || (y<2), evaluated at input coordinates.
- Stage 2 (following cycle):
  - Gx = (p02+2*p12+p22) - (p00+2*p10+p20).
  - Gy = (p20+2*p21+p22) - (p00+2*p01+p02).
  - p[row][col]; row 0 is top; col 0 is left.
  - Signed width W+3; no overflow is possible.
  - mag = |Gx|+|Gy| (width W+3, unsigned), then >> MAG_SHIFT, then saturate to 2^W-1.
  - edge_pixel = 0 if the border flag is set, else the saturated mag.
  - edge_valid = v1 delayed; edge_x = the stage-1 copy of x.
- Latency and throughput:
  - Latency is exactly 2 clk from pix_valid to edge_valid.
  - One pixel per cycle is sustained with pix_valid continuously high; there is no backpressure.
- Outputs:
  - edge_pixel/edge_x hold their last value while edge_valid=0.
  - The edge image is spatially shifted by (+1,+1) relative to the true centre; this is intentional and the downstream stage tolerates it.
- Border rows/columns: rows 0-1 and columns 0-1 of each frame always output 0. No flush is needed at frame end.
- Reset mid-frame: all state is cleared asynchronously. The next valid pixel is treated as (0,0) even without pix_sof.

Test Plan:
- Flat image (all pixels 128), 320x240 continuous valid:
  - expect exactly 76800 edge_valid pulses;
  - every edge_pixel=0;
  - first edge_valid exactly 2 cycles after the first pix_valid.
- Vertical step edge (x<100 → 0, x>=100 → 200), MAG_SHIFT=0:
  - for rows y>=2, edge_pixel=255 at input x=100 and 101;
  - 0 elsewhere.
  - Repeat with MAG_SHIFT=2: those outputs are 200.
- Horizontal step edge (y<50 → 0, y>=50 → 100):
  - rows y=50 and 51 (x>=2) give |Gy|=400, saturating to 255;
  - MAG_SHIFT=1 gives 200;
  - all other rows 0.
- Random pix_valid gaps (~40% duty) with the step-edge image:
  - output values and order match the continuous-valid run;
  - each edge_valid lags its pix_valid by exactly 2 cycles.
- pix_sof asserted mid-frame at counter (x=57, y=13):
  - that pixel is treated as (0,0);
  - next outputs report edge_x=0,1,2...;
  - rows 0-1 of the new frame output 0.
- rst_n pulsed low mid-frame:
  - edge_valid=0 immediately (asynchronously);
  - after release, the first pixel is treated as (0,0);
  - the following 2 rows output 0.

Source files
------------

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge-magnitude stage.
// One grayscale pixel in per pix_valid, one edge-magnitude pixel out exactly
// two cycles later. Two line buffers hold the previous two rows; a 3x3 window
// of taps is shifted left on every valid pixel. Outputs for the first two rows
// and columns of a frame are forced to zero, so stale line-buffer contents
// never reach the output.
module sobel_edge_stream #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int W          = 8,
    parameter int MAG_SHIFT  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    input  logic                         pix_sof,
    input  logic [W-1:0]                 pix_in,
    output logic                         edge_valid,
    output logic [W-1:0]                 edge_pixel,
    output logic [$clog2(IMG_WIDTH)-1:0] edge_x
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int MW = W + 3;

    logic [XW-1:0] x_reg, x_cur;
    logic [YW-1:0] y_reg, y_cur;

    // A start-of-frame pixel is always position (0,0), whatever the counters say.
    always_comb begin
        x_cur = pix_sof ? '0 : x_reg;
        y_cur = pix_sof ? '0 : y_reg;
    end

    // Raster position of the next expected pixel, advanced only on valid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (pix_valid) begin
            if (x_cur == XW'(IMG_WIDTH - 1)) begin
                x_reg <= '0;
                y_reg <= (y_cur == YW'(IMG_HEIGHT - 1)) ? '0 : y_cur + 1'b1;
            end else begin
                x_reg <= x_cur + 1'b1;
                y_reg <= y_cur;
            end
        end
    end

    // Line buffers: lb0 holds row y-1, lb1 holds row y-2 (contents not reset).
    logic [W-1:0] lb0_mem [IMG_WIDTH];
    logic [W-1:0] lb1_mem [IMG_WIDTH];
    logic [W-1:0] lb0_rd, lb1_rd;

    assign lb0_rd = lb0_mem[x_cur];
    assign lb1_rd = lb1_mem[x_cur];

    // Read-before-write: the old row y-1 value moves down into the row y-2 buffer.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb0_mem[x_cur] <= pix_in;
            lb1_mem[x_cur] <= lb0_mem[x_cur];
        end
    end

    // New right-hand window column, top to bottom.
    logic [W-1:0] col_in [3];
    assign col_in[0] = lb1_rd;
    assign col_in[1] = lb0_rd;
    assign col_in[2] = pix_in;

    // Flattened window: win[row*3 + col], row 0 on top, col 0 on the left.
    logic [W-1:0] win [9];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_row
            logic [W-1:0] tap_reg [3];

            // Shift this window row left by one column on each valid pixel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tap_reg[0] <= '0;
                    tap_reg[1] <= '0;
                    tap_reg[2] <= '0;
                end else if (pix_valid) begin
                    tap_reg[0] <= tap_reg[1];
                    tap_reg[1] <= tap_reg[2];
                    tap_reg[2] <= col_in[gi];
                end
            end

            assign win[gi*3 + 0] = tap_reg[0];
            assign win[gi*3 + 1] = tap_reg[1];
            assign win[gi*3 + 2] = tap_reg[2];
        end
    endgenerate

    logic          v1_reg;
    logic          border1_reg;
    logic [XW-1:0] x1_reg;

    // Stage 1 bookkeeping that travels alongside the freshly loaded window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg      <= 1'b0;
            border1_reg <= 1'b0;
            x1_reg      <= '0;
        end else begin
            v1_reg <= pix_valid;
            if (pix_valid) begin
                border1_reg <= (x_cur < XW'(2)) || (y_cur < YW'(2));
                x1_reg      <= x_cur;
            end
        end
    end

    logic [W+1:0]          gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [MW-1:0]  gx, gy;
    logic [MW-1:0]         abs_gx, abs_gy, mag, mag_sh;
    logic [W-1:0]          mag_sat;

    // Gradients, magnitude, scaling and saturation (W+3 bits cannot overflow).
    always_comb begin
        gx_pos  = {2'b00, win[2]} + {1'b0, win[5], 1'b0} + {2'b00, win[8]};
        gx_neg  = {2'b00, win[0]} + {1'b0, win[3], 1'b0} + {2'b00, win[6]};
        gy_pos  = {2'b00, win[6]} + {1'b0, win[7], 1'b0} + {2'b00, win[8]};
        gy_neg  = {2'b00, win[0]} + {1'b0, win[1], 1'b0} + {2'b00, win[2]};
        gx      = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy      = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
        abs_gx  = gx[MW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy  = gy[MW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag     = abs_gx + abs_gy;
        mag_sh  = mag >> MAG_SHIFT;
        mag_sat = (mag_sh > MW'((2 ** W) - 1)) ? '1 : mag_sh[W-1:0];
    end

    // Stage 2: registered outputs, held while no result is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_valid <= 1'b0;
            edge_pixel <= '0;
            edge_x     <= '0;
        end else begin
            edge_valid <= v1_reg;
            if (v1_reg) begin
                edge_pixel <= border1_reg ? '0 : mag_sat;
                edge_x     <= x1_reg;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Scoreboard bench for sobel_edge_stream on a reduced 16x12 frame.
// Three instances with MAG_SHIFT 0/1/2 share one input stream; expected
// results come from a frame-image Sobel reference computed at drive time.
module tb_sobel_edge_stream;
    localparam int IMW = 16;
    localparam int IMH = 12;
    localparam int PW  = 8;
    localparam int XW  = $clog2(IMW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic [PW-1:0] pix_in = '0;

    logic          edge_valid0, edge_valid1, edge_valid2;
    logic [PW-1:0] edge_pixel0, edge_pixel1, edge_pixel2;
    logic [XW-1:0] edge_x0, edge_x1, edge_x2;

    sobel_edge_stream #(.IMG_WIDTH(IMW), .IMG_HEIGHT(IMH), .W(PW), .MAG_SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_in(pix_in),
        .edge_valid(edge_valid0), .edge_pixel(edge_pixel0), .edge_x(edge_x0));
    sobel_edge_stream #(.IMG_WIDTH(IMW), .IMG_HEIGHT(IMH), .W(PW), .MAG_SHIFT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_in(pix_in),
        .edge_valid(edge_valid1), .edge_pixel(edge_pixel1), .edge_x(edge_x1));
    sobel_edge_stream #(.IMG_WIDTH(IMW), .IMG_HEIGHT(IMH), .W(PW), .MAG_SHIFT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_in(pix_in),
        .edge_valid(edge_valid2), .edge_pixel(edge_pixel2), .edge_x(edge_x2));

    always #5 clk = ~clk;

    typedef struct {
        int     x;
        int     e0;
        int     e1;
        int     e2;
        longint cyc;
    } exp_t;

    exp_t   sb_q [$];
    int     img [IMH][IMW];
    int     bx = 0;
    int     by = 0;
    longint cyc = 0;
    int     pulse_cnt = 0;
    int     total = 0;
    int     bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sobel_ref(input int x, input int y, input int sh);
        int gx, gy, m, wt;
        if (x < 2 || y < 2) return 0;
        gx = 0;
        gy = 0;
        for (int r = 0; r < 3; r++) begin
            wt = (r == 1) ? 2 : 1;
            gx += wt * (img[y-2+r][x] - img[y-2+r][x-2]);
            gy += wt * (img[y][x-2+r] - img[y-2][x-2+r]);
        end
        m = (iabs(gx) + iabs(gy)) >> sh;
        return (m > 255) ? 255 : m;
    endfunction

    // kind: 0 flat, 1 vertical step, 2 horizontal step, 3 random
    task automatic fill_img(input int kind);
        for (int y = 0; y < IMH; y++)
            for (int x = 0; x < IMW; x++)
                case (kind)
                    0: img[y][x] = 128;
                    1: img[y][x] = (x < 8) ? 0 : 200;
                    2: img[y][x] = (y < 6) ? 0 : 100;
                    default: img[y][x] = int'($urandom_range(0, 255));
                endcase
    endtask

    task automatic idle_cycle();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel (after optional random idle gaps) and push its expectation.
    task automatic send(input bit sof, input int duty);
        exp_t e;
        int   gaps;
        gaps = 0;
        while (duty < 100 && gaps < 20 && int'($urandom_range(0, 99)) >= duty) begin
            idle_cycle();
            gaps++;
        end
        if (sof) begin
            bx = 0;
            by = 0;
        end
        e.x   = bx;
        e.e0  = sobel_ref(bx, by, 0);
        e.e1  = sobel_ref(bx, by, 1);
        e.e2  = sobel_ref(bx, by, 2);
        e.cyc = cyc;
        sb_q.push_back(e);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_in    = PW'(img[by][bx]);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (bx == IMW - 1) begin
            bx = 0;
            by = (by == IMH - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4; i++) idle_cycle();
        chk(tag, sb_q.size(), 0);
    endtask

    task automatic run_frame(input int kind, input int duty, input bit use_sof);
        fill_img(kind);
        for (int i = 0; i < IMW * IMH; i++) send(use_sof && i == 0, duty);
    endtask

    // Output monitor: pop one expectation per output strobe.
    always @(negedge clk) begin
        if (rst_n && edge_valid0) begin
            exp_t e;
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("edge_x", edge_x0, e.x);
                chk("pix_sh0", edge_pixel0, e.e0);
                chk("pix_sh1", edge_pixel1, e.e1);
                chk("pix_sh2", edge_pixel2, e.e2);
                chk("valid_sh1", edge_valid1, 1);
                chk("valid_sh2", edge_valid2, 1);
                chk("latency", cyc - e.cyc, 2);
                $display("out x=%0d pix=%0d/%0d/%0d exp=%0d/%0d/%0d lat=%0d",
                         edge_x0, edge_pixel0, edge_pixel1, edge_pixel2,
                         e.e0, e.e1, e.e2, cyc - e.cyc);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", edge_valid0, 0);
        chk("rst_pixel", edge_pixel0, 0);
        chk("rst_x", edge_x0, 0);
        rst_n = 1'b1;
        idle_cycle();

        // Flat image: all zero, one output per input
        pulse_cnt = 0;
        run_frame(0, 100, 1'b1);
        drain("drain_flat");
        chk("flat_pulses", pulse_cnt, IMW * IMH);

        // Vertical and horizontal step edges, continuous valid
        run_frame(1, 100, 1'b1);
        drain("drain_vstep");
        run_frame(2, 100, 1'b1);
        drain("drain_hstep");

        // Vertical step with ~40% valid duty
        pulse_cnt = 0;
        run_frame(1, 40, 1'b1);
        drain("drain_vstep_gaps");
        chk("gap_pulses", pulse_cnt, IMW * IMH);

        // Random image with gaps
        run_frame(3, 60, 1'b1);
        drain("drain_random");

        // Start of frame asserted mid-frame at position (5,4)
        fill_img(3);
        for (int i = 0; i < 4 * IMW + 5; i++) send(1'b0, 100);
        run_frame(3, 100, 1'b1);
        drain("drain_sof_mid");

        // Asynchronous reset mid-frame
        fill_img(3);
        for (int i = 0; i < 5 * IMW + 3; i++) send(1'b0, 100);
        chk("pre_rst_valid", edge_valid0, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", edge_valid0, 0);
        chk("async_rst_pixel", edge_pixel0, 0);
        chk("async_rst_x", edge_x0, 0);
        sb_q.delete();
        bx = 0;
        by = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycle();
        run_frame(3, 100, 1'b0);
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
